key_load_ctrl: RTL

Sequential key-delivery controller for locked combinational cores such as the XOR/MUX-locked c432 variants. It accepts a key as a stream of WORD-bit beats and verifies it against a trailing checksum beat. On success it commits the key to the registered outputs that drive the core's XOR key inputs and the 4-input MUX LUT selectors (p1..p4 per LUT). Repeated bad loads lock the block out until reset.

---
 rtl/key_load_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/key_load_ctrl.sv
// Streams a key in WORD-bit beats, verifies it against a trailing XOR checksum beat and commits
// it to the locked core's XOR/LUT key inputs; repeated bad loads lock the block until reset.
module key_load_ctrl #(
    parameter int unsigned XOR_KEYS = 20,
    parameter int unsigned MUX_LUTS = 1,
    parameter int unsigned WORD     = 8,
    parameter int unsigned MAX_FAIL = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [WORD-1:0]                 s_data,
    output logic [XOR_KEYS-1:0]             xor_key,
    output logic [4*MUX_LUTS-1:0]           lut_key,
    output logic                            key_valid,
    output logic                            busy,
    output logic                            err,
    output logic                            locked_out,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

    localparam int unsigned KEY_BITS = XOR_KEYS + 4 * MUX_LUTS;
    localparam int unsigned BEATS    = (KEY_BITS + WORD - 1) / WORD;
    localparam int unsigned PAD_W    = BEATS * WORD;
    localparam int unsigned CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned FAIL_W   = $clog2(MAX_FAIL + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StCheck, StLockout} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       beat_q, beat_d;
    logic [KEY_BITS-1:0]    shadow_q, shadow_d;
    logic [WORD-1:0]        acc_q, acc_d;
    logic [XOR_KEYS-1:0]    xor_key_q, xor_key_d;
    logic [4*MUX_LUTS-1:0]  lut_key_q, lut_key_d;
    logic                   key_valid_q, key_valid_d;
    logic                   err_q, err_d;
    logic [FAIL_W-1:0]      fail_q, fail_d;

    logic                   beat_fire;
    logic                   start_ok;
    logic                   last_beat;
    logic                   check_ok;
    logic [FAIL_W-1:0]      fail_inc;
    logic                   fail_hit;
    logic [PAD_W-1:0]       ins_data;
    logic [PAD_W-1:0]       ins_mask;
    logic [PAD_W-1:0]       shadow_pad;

    assign beat_fire = s_valid && s_ready;
    assign start_ok  = start && (state_q != StLockout);
    assign last_beat = (beat_q == CNT_W'(BEATS - 1));
    assign check_ok  = (s_data == acc_q);
    assign fail_inc  = fail_q + 1'b1;
    assign fail_hit  = (fail_inc == FAIL_W'(MAX_FAIL));

    // Beat k lands at bit k*WORD; anything past KEY_BITS falls off when truncating the pad.
    assign ins_data   = PAD_W'(s_data) << (32'(beat_q) * WORD);
    assign ins_mask   = PAD_W'({WORD{1'b1}}) << (32'(beat_q) * WORD);
    assign shadow_pad = (PAD_W'(shadow_q) & ~ins_mask) | ins_data;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StLoad;
            end
            StLoad: begin
                if (start) begin
                    state_d = StLoad;
                end else if (beat_fire && last_beat) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                if (start) begin
                    state_d = StLoad;
                end else if (beat_fire) begin
                    if (!check_ok && fail_hit) begin
                        state_d = StLockout;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StLockout: begin
                state_d = StLockout;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy       = (state_q == StLoad) || (state_q == StCheck);
        s_ready    = busy && !start;
        locked_out = (state_q == StLockout);
    end

    // Datapath next-state
    always_comb begin
        beat_d      = beat_q;
        shadow_d    = shadow_q;
        acc_d       = acc_q;
        xor_key_d   = xor_key_q;
        lut_key_d   = lut_key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        fail_d      = fail_q;
        if (start_ok) begin
            beat_d   = '0;
            shadow_d = '0;
            acc_d    = '0;
            err_d    = 1'b0;
        end else if (beat_fire && state_q == StLoad) begin
            shadow_d = shadow_pad[KEY_BITS-1:0];
            acc_d    = acc_q ^ s_data;
            beat_d   = beat_q + 1'b1;
        end else if (beat_fire && state_q == StCheck) begin
            if (check_ok) begin
                xor_key_d   = shadow_q[XOR_KEYS-1:0];
                lut_key_d   = shadow_q[KEY_BITS-1:XOR_KEYS];
                key_valid_d = 1'b1;
                fail_d      = '0;
            end else begin
                err_d  = 1'b1;
                fail_d = fail_inc;
                // Entering lockout drops the committed key on the same edge.
                if (fail_hit) begin
                    xor_key_d   = '0;
                    lut_key_d   = '0;
                    key_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q      <= '0;
            shadow_q    <= '0;
            acc_q       <= '0;
            xor_key_q   <= '0;
            lut_key_q   <= '0;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            fail_q      <= '0;
        end else begin
            beat_q      <= beat_d;
            shadow_q    <= shadow_d;
            acc_q       <= acc_d;
            xor_key_q   <= xor_key_d;
            lut_key_q   <= lut_key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
        end
    end

    assign xor_key   = xor_key_q;
    assign lut_key   = lut_key_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;
    assign fail_cnt  = fail_q;

endmodule
